// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD run controller: the FSM state encoding,
// the digit width and the single-digit BCD increment helper.
package bcd_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One BCD digit step: 9 rolls over to 0, everything else adds one.
  function automatic logic [DIGIT_W-1:0] bcd_digit_inc(input logic [DIGIT_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Front-panel / display bus of the BCD run controller.
// Optional macro BCD_CTRL_LAP_EN adds the LAP strobe and LAP_COUNT snapshot.
interface bcd_count_ctrl_if #(
  parameter int NDIG = 2
);
  logic              START;
  logic              STOP;
  logic              CLEAR;
  logic [4*NDIG-1:0] LIMIT;
  logic [4*NDIG-1:0] COUNT;
  logic              BUSY;
  logic              DONE;
  logic              WRAP;
`ifdef BCD_CTRL_LAP_EN
  logic              LAP;
  logic [4*NDIG-1:0] LAP_COUNT;

  modport master (output START, STOP, CLEAR, LIMIT, LAP,
                  input  COUNT, BUSY, DONE, WRAP, LAP_COUNT);
  modport slave  (input  START, STOP, CLEAR, LIMIT, LAP,
                  output COUNT, BUSY, DONE, WRAP, LAP_COUNT);
`else
  modport master (output START, STOP, CLEAR, LIMIT,
                  input  COUNT, BUSY, DONE, WRAP);
  modport slave  (input  START, STOP, CLEAR, LIMIT,
                  output COUNT, BUSY, DONE, WRAP);
`endif
endinterface

// File: rtl/bcd_count_ctrl_digit.sv
// One decade of the cascaded BCD counter. CO asserts when this digit is
// enabled while at 9, i.e. when the next digit up must advance.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CLR,
  input  logic               EN,
  output logic [DIGIT_W-1:0] Q,
  output logic               CO
);

  // Digit register: cleared by reset or CLEAR, otherwise steps on enable.
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      Q <= '0;
    end else if (EN) begin
      Q <= bcd_digit_inc(Q);
    end
  end

  assign CO = EN && (Q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run controller for an NDIG-digit BCD stopwatch/timer counter.
// IDLE/RUN/PAUSE/DONE sequencing, CLK prescaler, digit carry chain,
// programmable terminal limit (0 = free-run) and wrap pulse.
// Optional macro BCD_CTRL_LAP_EN adds a lap snapshot register.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int PRESCALE = 4
)(
  input  logic            CLK,
  input  logic            RESET,
  bcd_count_ctrl_if.slave bus
);

  localparam int CW   = DIGIT_W * NDIG;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t          state;
  logic [PS_W-1:0] ps;
  logic            ps_last;
  logic            tick;
  logic            busy_r;
  logic            done_r;
  logic            wrap_r;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [NDIG:0]   en;
  logic            limit_hit;

  assign ps_last = (ps == PS_W'(PRESCALE - 1));
  // STOP or CLEAR in the same cycle swallow the tick.
  assign tick    = (state == ST_RUN) && ps_last && !bus.STOP && !bus.CLEAR;
  assign en[0]   = tick;

  // Carry chain: each digit advances when every lower digit is rolling over.
  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    bcd_digit u_digit (
      .CLK   (CLK),
      .RESET (RESET),
      .CLR   (bus.CLEAR),
      .EN    (en[k]),
      .Q     (cnt[k*DIGIT_W +: DIGIT_W]),
      .CO    (en[k+1])
    );
    assign cnt_nxt[k*DIGIT_W +: DIGIT_W] = en[k] ? bcd_digit_inc(cnt[k*DIGIT_W +: DIGIT_W])
                                                 : cnt[k*DIGIT_W +: DIGIT_W];
  end

  // cnt_nxt is always valid BCD, so a LIMIT with a nibble above 9 never matches.
  assign limit_hit = (bus.LIMIT != '0) && (cnt_nxt == bus.LIMIT);

  // Control FSM with prescaler and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      ps     <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= en[NDIG];
      if (bus.CLEAR) begin
        state  <= ST_IDLE;
        ps     <= '0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
        wrap_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            if (bus.START && !bus.STOP) begin
              state  <= ST_RUN;
              busy_r <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.STOP) begin
              state  <= ST_PAUSE;
              busy_r <= 1'b0;
            end else if (ps_last) begin
              ps <= '0;
              if (limit_hit) begin
                state  <= ST_DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end
            end else begin
              ps <= ps + PS_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.COUNT = cnt;
  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
  assign bus.WRAP  = wrap_r;

`ifdef BCD_CTRL_LAP_EN
  logic [CW-1:0] lap_r;

  // Lap snapshot of the pre-increment count, only while RUN or PAUSE.
  always_ff @(posedge CLK) begin
    if (RESET || bus.CLEAR) begin
      lap_r <= '0;
    end else if (bus.LAP && (state == ST_RUN || state == ST_PAUSE)) begin
      lap_r <= cnt;
    end
  end

  assign bus.LAP_COUNT = lap_r;
`endif

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (PRESCALE=1 and PRESCALE=4, NDIG=2)
// share the same control inputs and are compared every cycle against a
// decimal-arithmetic reference model, plus directed scenario checks.
module tb_bcd_count_ctrl;

  localparam int NDIG = 2;
  localparam int MOD  = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [4*NDIG-1:0] limit = '0;

  int vectors = 0;
  int miscompares = 0;

  int m_st[2], m_n[2], m_ps[2], m_lap[2];
  bit m_wrap[2];
  int pre[2] = '{1, 4};

  always #5 clk = ~clk;

  bcd_count_ctrl_if #(.NDIG(NDIG)) if1 ();
  bcd_count_ctrl_if #(.NDIG(NDIG)) if4 ();

  assign if1.START = start; assign if4.START = start;
  assign if1.STOP  = stop;  assign if4.STOP  = stop;
  assign if1.CLEAR = clear; assign if4.CLEAR = clear;
  assign if1.LIMIT = limit; assign if4.LIMIT = limit;
`ifdef BCD_CTRL_LAP_EN
  assign if1.LAP = lap; assign if4.LAP = lap;
`endif

  bcd_count_ctrl #(.NDIG(NDIG), .PRESCALE(1)) dut_p1 (.CLK(clk), .RESET(rst), .bus(if1));
  bcd_count_ctrl #(.NDIG(NDIG), .PRESCALE(4)) dut_p4 (.CLK(clk), .RESET(rst), .bus(if4));

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r = '0;
    int v = n;
    for (int k = 0; k < NDIG; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal value of LIMIT, or -1 when some nibble is not a BCD digit.
  function automatic int lim_dec(input logic [4*NDIG-1:0] l);
    int r = 0;
    int w = 1;
    logic [3:0] nib;
    for (int k = 0; k < NDIG; k++) begin
      nib = l[k*4 +: 4];
      if (nib > 4'd9) return -1;
      r = r + int'(nib) * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int lim;
    lim = lim_dec(limit);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = M_IDLE; m_n[i] = 0; m_ps[i] = 0; m_wrap[i] = 0; m_lap[i] = 0;
      end else begin
        m_wrap[i] = 0;
        if (clear) begin
          m_st[i] = M_IDLE; m_n[i] = 0; m_ps[i] = 0; m_lap[i] = 0;
        end else begin
`ifdef BCD_CTRL_LAP_EN
          if (lap && (m_st[i] == M_RUN || m_st[i] == M_PAUSE)) m_lap[i] = m_n[i];
`endif
          case (m_st[i])
            M_IDLE, M_PAUSE: if (start && !stop) m_st[i] = M_RUN;
            M_RUN: begin
              if (stop) m_st[i] = M_PAUSE;
              else if (m_ps[i] == pre[i] - 1) begin
                m_ps[i] = 0;
                if (m_n[i] == MOD - 1) m_wrap[i] = 1;
                m_n[i] = (m_n[i] + 1) % MOD;
                if (lim > 0 && m_n[i] == lim) m_st[i] = M_DONE;
              end else m_ps[i] = m_ps[i] + 1;
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check_all();
    chk("p1_count", 32'(if1.COUNT), to_bcd(m_n[0]));
    chk("p1_busy",  32'(if1.BUSY),  32'(m_st[0] == M_RUN));
    chk("p1_done",  32'(if1.DONE),  32'(m_st[0] == M_DONE));
    chk("p1_wrap",  32'(if1.WRAP),  32'(m_wrap[0]));
    chk("p4_count", 32'(if4.COUNT), to_bcd(m_n[1]));
    chk("p4_busy",  32'(if4.BUSY),  32'(m_st[1] == M_RUN));
    chk("p4_done",  32'(if4.DONE),  32'(m_st[1] == M_DONE));
    chk("p4_wrap",  32'(if4.WRAP),  32'(m_wrap[1]));
`ifdef BCD_CTRL_LAP_EN
    chk("p1_lap", 32'(if1.LAP_COUNT), to_bcd(m_lap[0]));
    chk("p4_lap", 32'(if4.LAP_COUNT), to_bcd(m_lap[1]));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    int r;
    // Reset state
    cyc(); cyc();
    chk("rst_count", 32'(if4.COUNT), 32'h0);
    chk("rst_busy",  32'(if4.BUSY),  32'h0);
    rst = 1'b0;

    // Free-run wrap, PRESCALE=1
    limit = '0;
    pulse_start();
    repeat (99) cyc();
    chk("wrap_at99", 32'(if1.COUNT), 32'h99);
    chk("wrap_pre",  32'(if1.WRAP),  32'h0);
    cyc();
    chk("wrap_cnt0", 32'(if1.COUNT), 32'h00);
    chk("wrap_pulse", 32'(if1.WRAP), 32'h1);
    chk("wrap_busy", 32'(if1.BUSY), 32'h1);
    cyc();
    chk("wrap_once", 32'(if1.WRAP), 32'h0);
    chk("wrap_cnt1", 32'(if1.COUNT), 32'h01);

    // Reset held 3 cycles mid-run at 0x37
    clear = 1'b1; cyc(); clear = 1'b0;
    pulse_start();
    repeat (37) cyc();
    chk("mid_37", 32'(if1.COUNT), 32'h37);
    rst = 1'b1; repeat (3) cyc(); rst = 1'b0;
    chk("rst_mid_count", 32'(if1.COUNT), 32'h0);
    chk("rst_mid_busy",  32'(if1.BUSY),  32'h0);
    chk("rst_mid_done",  32'(if4.DONE),  32'h0);
    chk("rst_mid_wrap",  32'(if1.WRAP),  32'h0);

    // Limit 0x15, PRESCALE=4
    limit = 8'h15;
    pulse_start();
    repeat (59) cyc();
    chk("lim_pre_cnt",  32'(if4.COUNT), 32'h14);
    chk("lim_pre_done", 32'(if4.DONE),  32'h0);
    cyc();
    chk("lim_cnt",  32'(if4.COUNT), 32'h15);
    chk("lim_done", 32'(if4.DONE),  32'h1);
    pulse_start(); cyc();
    chk("done_hold", 32'(if4.DONE), 32'h1);
    chk("done_cnt",  32'(if4.COUNT), 32'h15);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("done_clr", 32'(if4.COUNT), 32'h0);

    // Pause keeps count and prescaler phase
    limit = '0;
    pulse_start();
    repeat (30) cyc();
    chk("pause_07", 32'(if4.COUNT), 32'h07);
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (20) cyc();
    chk("pause_hold", 32'(if4.COUNT), 32'h07);
    chk("pause_busy", 32'(if4.BUSY),  32'h0);
    pulse_start(); cyc();
    chk("resume_1", 32'(if4.COUNT), 32'h07);
    cyc();
    chk("resume_2", 32'(if4.COUNT), 32'h08);

    // CLEAR beats STOP and START
    start = 1'b1; stop = 1'b1; clear = 1'b1; cyc();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    chk("prio_cnt",  32'(if4.COUNT), 32'h0);
    chk("prio_busy", 32'(if4.BUSY),  32'h0);

`ifdef BCD_CTRL_LAP_EN
    pulse_start();
    repeat (42) cyc();
    lap = 1'b1; cyc(); lap = 1'b0;
    chk("lap_val", 32'(if1.LAP_COUNT), 32'h42);
    chk("lap_cnt", 32'(if1.COUNT),     32'h43);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("lap_clr", 32'(if1.LAP_COUNT), 32'h0);
`endif

    // Randomized control traffic against the model
    for (int t = 0; t < 800; t++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      clear = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      lap   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0: limit = '0;
          1: limit = (4*NDIG)'(to_bcd(int'($urandom_range(1, 30))));
          2: limit = (4*NDIG)'(to_bcd(int'($urandom_range(0, 99))));
          default: limit = 8'hA3;
        endcase
      end
      cyc();
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0; lap = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
